// File: rtl/load_store_unit.sv
// load_store_unit
//   Core-side initiator for the byte-addressed data-memory port. It accepts
//   one load/store at a time from execute and drives the memory port with
//   registered outputs. Loads wait out the memory's one-edge read latency and
//   return a sign- or zero-extended result. Illegal sizes and misaligned
//   accesses (when not allowed) return a fault without touching memory.
//
// Ports
//   clock, reset_n            clock, asynchronous active-low reset
//   request_valid/ready       request handshake (ready only in IDLE)
//   request_write             1 store, 0 load
//   request_size              0 byte, 1 half, 2 word, 3 illegal
//   request_unsigned          zero-extend loads when 1
//   request_address           byte address
//   request_write_data        store data (low bytes used)
//   response_valid            one-cycle completion pulse
//   response_fault            qualifies response_valid
//   response_read_data        extended load data, 0 for stores/faults
//   memory_address            byte address to memory (registered)
//   memory_write_value        store data, byte0 at memory_address (registered)
//   memory_read_value         memory read data, valid the cycle after READ
//   memory_write_sections     bit0 byte0, bit1 byte1, bit2 bytes2+3; 0 = read
module load_store_unit #(
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter logic [31:0] RESET_ADDRESS    = 32'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic        request_write,
  input  logic [1:0]  request_size,
  input  logic        request_unsigned,
  input  logic [31:0] request_address,
  input  logic [31:0] request_write_data,
  output logic        response_valid,
  output logic        response_fault,
  output logic [31:0] response_read_data,
  output logic [31:0] memory_address,
  output logic [31:0] memory_write_value,
  input  logic [31:0] memory_read_value,
  output logic [2:0]  memory_write_sections
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    RESPOND = 3'd3,
    FAULT   = 3'd4
  } state_t;

  state_t      state, state_next;
  logic        accept;
  logic        misaligned;
  logic [1:0]  size_q;
  logic        unsigned_q;

  function automatic logic [2:0] section_mask(input logic [1:0] size);
    case (size)
      2'd0:    section_mask = 3'b001;
      2'd1:    section_mask = 3'b011;
      default: section_mask = 3'b111;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] value,
                                              input logic [1:0]  size,
                                              input logic        zero_ext);
    case (size)
      2'd0:    extend_load = {{24{~zero_ext & value[7]}}, value[7:0]};
      2'd1:    extend_load = {{16{~zero_ext & value[15]}}, value[15:0]};
      default: extend_load = value;
    endcase
  endfunction

  assign accept = (state == IDLE) && request_valid;

  always_comb begin
    misaligned = 1'b0;
    case (request_size)
      2'd1:    misaligned = request_address[0];
      2'd2:    misaligned = (request_address[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (request_size == 2'd3)
            state_next = FAULT;
          else if (!ALLOW_MISALIGNED && misaligned)
            state_next = FAULT;
          else if (request_write)
            state_next = WRITE;
          else
            state_next = READ;
        end
      end
      WRITE:   state_next = IDLE;
      READ:    state_next = RESPOND;
      RESPOND: state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Memory-side outputs are registered and loaded on the accept edge so they
  // are stable for the whole WRITE/READ cycle. Sections only go nonzero for
  // a cycle that will actually be WRITE; reset clears them asynchronously so
  // an interrupted store never lands.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      memory_address        <= RESET_ADDRESS;
      memory_write_value    <= 32'h0;
      memory_write_sections <= 3'b000;
    end else begin
      if (accept) begin
        memory_address     <= request_address;
        memory_write_value <= request_write_data;
      end
      memory_write_sections <= (state_next == WRITE) ? section_mask(request_size) : 3'b000;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      size_q     <= request_size;
      unsigned_q <= request_unsigned;
    end
  end

  // Read data only becomes valid after the memory's capture edge, so the
  // response is decoded from state and formed combinationally in RESPOND.
  assign request_ready      = (state == IDLE);
  assign response_valid     = (state == WRITE) || (state == RESPOND) || (state == FAULT);
  assign response_fault     = (state == FAULT);
  assign response_read_data = (state == RESPOND) ?
                              extend_load(memory_read_value, size_q, unsigned_q) : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clock;
  logic        reset_n;
  logic        mem_clear;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_address;
  logic [31:0] req_wdata;

  // Instance a: misaligned allowed, nonzero reset address
  logic        ready_a, valid_a, fault_a;
  logic [31:0] rd_a, addr_a, wv_a, mrv_a;
  logic [2:0]  sec_a;
  // Instance b: misaligned forbidden
  logic        ready_b, valid_b, fault_b;
  logic [31:0] rd_b, addr_b, wv_b, mrv_b;
  logic [2:0]  sec_b;

  logic [7:0] mem_a [0:255];
  logic [7:0] mem_b [0:255];

  int errors = 0;
  int checks = 0;

  load_store_unit #(.ALLOW_MISALIGNED(1'b1), .RESET_ADDRESS(32'h0000_0100)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .request_valid(req_valid), .request_ready(ready_a),
    .request_write(req_write), .request_size(req_size),
    .request_unsigned(req_unsigned), .request_address(req_address),
    .request_write_data(req_wdata),
    .response_valid(valid_a), .response_fault(fault_a), .response_read_data(rd_a),
    .memory_address(addr_a), .memory_write_value(wv_a),
    .memory_read_value(mrv_a), .memory_write_sections(sec_a)
  );

  load_store_unit #(.ALLOW_MISALIGNED(1'b0), .RESET_ADDRESS(32'h0)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .request_valid(req_valid), .request_ready(ready_b),
    .request_write(req_write), .request_size(req_size),
    .request_unsigned(req_unsigned), .request_address(req_address),
    .request_write_data(req_wdata),
    .response_valid(valid_b), .response_fault(fault_b), .response_read_data(rd_b),
    .memory_address(addr_b), .memory_write_value(wv_b),
    .memory_read_value(mrv_b), .memory_write_sections(sec_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory models: write enabled sections, otherwise register a read.
  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 8'h00;
    end else if (sec_a != 3'b000) begin
      if (sec_a[0]) mem_a[addr_a[7:0]]         <= wv_a[7:0];
      if (sec_a[1]) mem_a[addr_a[7:0] + 8'd1]  <= wv_a[15:8];
      if (sec_a[2]) begin
        mem_a[addr_a[7:0] + 8'd2] <= wv_a[23:16];
        mem_a[addr_a[7:0] + 8'd3] <= wv_a[31:24];
      end
    end else begin
      mrv_a <= {mem_a[addr_a[7:0] + 8'd3], mem_a[addr_a[7:0] + 8'd2],
                mem_a[addr_a[7:0] + 8'd1], mem_a[addr_a[7:0]]};
    end
  end

  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 8'h00;
    end else if (sec_b != 3'b000) begin
      if (sec_b[0]) mem_b[addr_b[7:0]]         <= wv_b[7:0];
      if (sec_b[1]) mem_b[addr_b[7:0] + 8'd1]  <= wv_b[15:8];
      if (sec_b[2]) begin
        mem_b[addr_b[7:0] + 8'd2] <= wv_b[23:16];
        mem_b[addr_b[7:0] + 8'd3] <= wv_b[31:24];
      end
    end else begin
      mrv_b <= {mem_b[addr_b[7:0] + 8'd3], mem_b[addr_b[7:0] + 8'd2],
                mem_b[addr_b[7:0] + 8'd1], mem_b[addr_b[7:0]]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_address  = a;
    req_wdata    = d;
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, sz, u, a, 32'h0);
    step();
    req_valid = 1'b0;
    check({tag, ".read_valid"}, {31'd0, valid_a}, 32'd0);
    check({tag, ".read_sec"}, {29'd0, sec_a}, 32'd0);
    check({tag, ".read_addr"}, addr_a, a);
    step();
    check({tag, ".resp_valid"}, {31'd0, valid_a}, 32'd1);
    check({tag, ".resp_fault"}, {31'd0, fault_a}, 32'd0);
    check({tag, ".data_a"}, rd_a, exp);
    check({tag, ".data_b"}, rd_b, exp);
    step();
    check({tag, ".idle_ready"}, {31'd0, ready_a}, 32'd1);
  endtask

  initial begin
    int resp_count;
    logic [5:0] ready_seen;
    reset_n = 1'b0;
    mem_clear = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_address = 32'h0;
    req_wdata = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    mem_clear = 1'b0;

    check("rst.ready", {31'd0, ready_a}, 32'd1);
    check("rst.valid", {31'd0, valid_a}, 32'd0);
    check("rst.fault", {31'd0, fault_a}, 32'd0);
    check("rst.rdata", rd_a, 32'h0);
    check("rst.sec", {29'd0, sec_a}, 32'd0);
    check("rst.wv", wv_a, 32'h0);
    check("rst.addr_a", addr_a, 32'h0000_0100);
    check("rst.addr_b", addr_b, 32'h0);
    reset_n = 1'b1;

    // Word store 0x80
    drive(1'b1, 2'd2, 1'b0, 32'h80, 32'hDEADBEEF);
    step();
    req_valid = 1'b0;
    check("st.sec_a", {29'd0, sec_a}, 32'b111);
    check("st.sec_b", {29'd0, sec_b}, 32'b111);
    check("st.addr", addr_a, 32'h80);
    check("st.wv", wv_a, 32'hDEADBEEF);
    check("st.valid", {31'd0, valid_a}, 32'd1);
    check("st.fault", {31'd0, fault_a}, 32'd0);
    check("st.ready", {31'd0, ready_a}, 32'd0);
    check("st.rdata", rd_a, 32'h0);
    step();
    check("st.after_valid", {31'd0, valid_a}, 32'd0);
    check("st.after_sec", {29'd0, sec_a}, 32'd0);
    check("st.mem_a", {mem_a[8'h83], mem_a[8'h82], mem_a[8'h81], mem_a[8'h80]}, 32'hDEADBEEF);
    check("st.mem_b", {mem_b[8'h83], mem_b[8'h82], mem_b[8'h81], mem_b[8'h80]}, 32'hDEADBEEF);

    do_load("ld_b_s", 2'd0, 1'b0, 32'h83, 32'hFFFFFFDE);
    do_load("ld_b_u", 2'd0, 1'b1, 32'h83, 32'h000000DE);
    do_load("ld_h_u", 2'd1, 1'b1, 32'h82, 32'h0000DEAD);
    do_load("ld_h_s", 2'd1, 1'b0, 32'h82, 32'hFFFFDEAD);
    do_load("ld_w",   2'd2, 1'b0, 32'h80, 32'hDEADBEEF);

    // Misaligned word store: a performs it, b faults without writing
    drive(1'b1, 2'd2, 1'b0, 32'h81, 32'h11223344);
    step();
    req_valid = 1'b0;
    check("mis.sec_a", {29'd0, sec_a}, 32'b111);
    check("mis.addr_a", addr_a, 32'h81);
    check("mis.fault_a", {31'd0, fault_a}, 32'd0);
    check("mis.valid_b", {31'd0, valid_b}, 32'd1);
    check("mis.fault_b", {31'd0, fault_b}, 32'd1);
    check("mis.sec_b", {29'd0, sec_b}, 32'd0);
    check("mis.rdata_b", rd_b, 32'h0);
    step();
    check("mis.sec_b2", {29'd0, sec_b}, 32'd0);
    check("mis.mem_a", {mem_a[8'h84], mem_a[8'h83], mem_a[8'h82], mem_a[8'h81]}, 32'h11223344);
    check("mis.mem_b", {mem_b[8'h83], mem_b[8'h82], mem_b[8'h81], mem_b[8'h80]}, 32'hDEADBEEF);
    check("mis.ready_b", {31'd0, ready_b}, 32'd1);

    // Illegal size load faults on both
    drive(1'b0, 2'd3, 1'b0, 32'h80, 32'h0);
    step();
    req_valid = 1'b0;
    check("sz3.valid_a", {31'd0, valid_a}, 32'd1);
    check("sz3.fault_a", {31'd0, fault_a}, 32'd1);
    check("sz3.fault_b", {31'd0, fault_b}, 32'd1);
    check("sz3.rdata_a", rd_a, 32'h0);
    check("sz3.sec_a", {29'd0, sec_a}, 32'd0);
    check("sz3.ready_a", {31'd0, ready_a}, 32'd0);
    step();
    check("sz3.after_valid", {31'd0, valid_a}, 32'd0);

    // Reset asserted in the middle of a half store
    drive(1'b1, 2'd1, 1'b0, 32'h10, 32'hCAFE1234);
    step();
    req_valid = 1'b0;
    check("rw.sec_before", {29'd0, sec_a}, 32'b011);
    reset_n = 1'b0;
    #1;
    check("rw.sec_a", {29'd0, sec_a}, 32'd0);
    check("rw.sec_b", {29'd0, sec_b}, 32'd0);
    check("rw.valid", {31'd0, valid_a}, 32'd0);
    check("rw.ready", {31'd0, ready_a}, 32'd1);
    check("rw.addr", addr_a, 32'h0000_0100);
    check("rw.wv", wv_a, 32'h0);
    step();
    check("rw.mem_a", {16'h0, mem_a[8'h11], mem_a[8'h10]}, 32'h0);
    check("rw.mem_b", {16'h0, mem_b[8'h11], mem_b[8'h10]}, 32'h0);
    reset_n = 1'b1;

    // Request held continuously: accepts only from IDLE, first right after reset
    drive(1'b0, 2'd0, 1'b1, 32'h80, 32'h0);
    resp_count = 0;
    ready_seen = 6'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      ready_seen[i] = ready_a;
      if (valid_a) begin
        resp_count++;
        check("b2b.data", rd_a, 32'h000000EF);
      end
    end
    req_valid = 1'b0;
    check("b2b.ready_pattern", {26'd0, ready_seen}, 32'b100100);
    check("b2b.responses", resp_count, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
